// File: rtl/fxp_conv_pipe_pkg.sv
// fxp_conv_pipe_pkg: fixed-point format descriptor, rounding modes
// and range helpers shared by the format converter.
package fxp_conv_pipe_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;

  localparam dconf_t DEF_DCONF_FXP =
    '{sign: 1'b1, prec: 8'd16, frac: 8'd8};
  localparam dconf_t DEF_DCONFL_FXP =
    '{sign: 1'b1, prec: 8'd8, frac: 8'd4};

  typedef enum logic [1:0] {
    RND_TRUNC,
    RND_HALF_UP,
    RND_HALF_EVEN
  } rnd_mode_t;

  function automatic logic signed [63:0] fxp_max(input dconf_t c);
    if (c.sign)
      return (64'sd1 <<< (c.prec - 8'd1)) - 64'sd1;
    return (64'sd1 <<< c.prec) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] fxp_min(input dconf_t c);
    if (c.sign)
      return -(64'sd1 <<< (c.prec - 8'd1));
    return 64'sd0;
  endfunction

  // Aligned width: room for the larger integer part, the output
  // fraction, a rounding carry and a sign bit.
  function automatic int fxp_iw(input dconf_t i, input dconf_t o);
    int ii;
    int oi;
    ii = int'(i.prec) - int'(i.frac);
    oi = int'(o.prec) - int'(o.frac);
    return (ii > oi ? ii : oi) + int'(o.frac) + 2;
  endfunction

endpackage

// File: rtl/fxp_conv_lane.sv
// fxp_conv_lane: one lane of the converter, purely combinational.
// in_data -> al_data (align/round); s1_data -> out_data/out_sat (range).
module fxp_conv_lane
  import fxp_conv_pipe_pkg::*;
#(
  parameter dconf_t    I_CONF = DEF_DCONF_FXP,
  parameter dconf_t    O_CONF = DEF_DCONFL_FXP,
  parameter rnd_mode_t RND    = RND_HALF_UP,
  parameter bit        SAT_EN = 1'b1,
  localparam int IP = int'(I_CONF.prec),
  localparam int OP = int'(O_CONF.prec),
  localparam int IW = fxp_iw(I_CONF, O_CONF)
) (
  input  logic [IP-1:0] in_data,
  output logic [IW-1:0] al_data,
  input  logic [IW-1:0] s1_data,
  output logic [OP-1:0] out_data,
  output logic          out_sat
);

  localparam int D  = int'(I_CONF.frac) - int'(O_CONF.frac);
  localparam int XW = IP + IW + 2;
  localparam int LS = D < 0 ? -D : 0;
  localparam int RS = D > 0 ? D : 0;
  localparam int HS = D > 0 ? D - 1 : 0;

  typedef logic signed [XW-1:0] xw_t;

  function automatic logic [IW-1:0] align_rnd(
    input logic [IP-1:0] x
  );
    xw_t  v;
    xw_t  q;
    xw_t  rem;
    xw_t  half;
    xw_t  r;
    logic inc;
    v    = I_CONF.sign ? xw_t'($signed(x)) : xw_t'(x);
    q    = v >>> RS;
    rem  = v & ((xw_t'(1) <<< RS) - xw_t'(1));
    half = xw_t'(1) <<< HS;
    inc  = 1'b0;
    unique case (1'b1)
      (RND == RND_HALF_UP):   inc = rem >= half;
      (RND == RND_HALF_EVEN): inc = (rem > half) ||
                                    (rem == half && q[0]);
      default:                inc = 1'b0;
    endcase
    if (D <= 0)
      r = v <<< LS;
    else
      r = q + xw_t'({{(XW-1){1'b0}}, inc});
    return IW'(r);
  endfunction

  function automatic logic [OP:0] range_chk(
    input logic [IW-1:0] v
  );
    logic signed [63:0] w;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    logic               hi;
    logic               lo;
    logic [OP-1:0]      d;
    w  = 64'($signed(v));
    mx = fxp_max(O_CONF);
    mn = fxp_min(O_CONF);
    hi = w > mx;
    lo = w < mn;
    d  = v[OP-1:0];
    if (SAT_EN && hi) d = OP'(mx);
    if (SAT_EN && lo) d = OP'(mn);
    return {hi | lo, d};
  endfunction

  logic [OP:0] rc;

  assign al_data  = align_rnd(in_data);
  assign rc       = range_chk(s1_data);
  assign out_sat  = rc[OP];
  assign out_data = rc[OP-1:0];

endmodule

// File: rtl/fxp_conv_pipe.sv
// fxp_conv_pipe: LANES-wide fixed-point converter, S1 align/round,
// S2 range check; valid/ready in/out, sticky sat_cnt with clr_cnt.
module fxp_conv_pipe
  import fxp_conv_pipe_pkg::*;
#(
  parameter dconf_t    I_CONF = DEF_DCONF_FXP,
  parameter dconf_t    O_CONF = DEF_DCONFL_FXP,
  parameter int        LANES  = 4,
  parameter rnd_mode_t RND    = RND_HALF_UP,
  parameter bit        SAT_EN = 1'b1,
  parameter int        CNT_W  = 16,
  localparam int IP = int'(I_CONF.prec),
  localparam int OP = int'(O_CONF.prec)
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*IP-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*OP-1:0] out_data,
  output logic [LANES-1:0]    out_sat,
  input  logic                clr_cnt,
  output logic [CNT_W-1:0]    sat_cnt
);

  localparam int IW = fxp_iw(I_CONF, O_CONF);

  logic                s1_v;
  logic [LANES*IW-1:0] s1_d;
  logic [LANES*IW-1:0] al;
  logic [LANES*OP-1:0] rc;
  logic [LANES-1:0]    sc;
  logic                s2_go;
  logic                s1_go;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fxp_conv_lane #(
      .I_CONF (I_CONF),
      .O_CONF (O_CONF),
      .RND    (RND),
      .SAT_EN (SAT_EN)
    ) u_lane (
      .in_data  (in_data[k*IP +: IP]),
      .al_data  (al[k*IW +: IW]),
      .s1_data  (s1_d[k*IW +: IW]),
      .out_data (rc[k*OP +: OP]),
      .out_sat  (sc[k])
    );
  end

  assign s2_go    = !out_valid || out_ready;
  assign s1_go    = !s1_v || s2_go;
  assign in_ready = s1_go;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      s1_v      <= 1'b0;
      s1_d      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else begin
      if (s1_go) begin
        s1_v <= in_valid;
        if (in_valid) s1_d <= al;
      end
      if (s2_go) begin
        out_valid <= s1_v;
        if (s1_v) begin
          out_data <= rc;
          out_sat  <= sc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)
      sat_cnt <= '0;
    else if (clr_cnt)
      sat_cnt <= '0;
    else if (out_valid && out_ready && |out_sat &&
             sat_cnt != '1)
      sat_cnt <= sat_cnt + 1'b1;
  end

endmodule

// File: tb/tb_fxp_conv_pipe.sv
// tb_fxp_conv_pipe: scoreboard bench driving six converter variants
// with a shared stream and checking every output beat and counter.
module tb_fxp_conv_pipe;
  import fxp_conv_pipe_pkg::*;

  localparam dconf_t O32 = '{sign: 1'b1, prec: 8'd32, frac: 8'd16};

  logic        clk;
  logic        reset_;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        clr_cnt;

  logic [5:0]   ir;
  logic [5:0]   ov;
  logic [31:0]  d0, d1, d2, d3, d4;
  logic [127:0] d5;
  logic [3:0]   os [6];
  logic [15:0]  cnt0, cnt1, cnt2, cnt3, cnt5;
  logic [3:0]   cnt4;
  logic [127:0] od [6];

  assign od[0] = {96'b0, d0};
  assign od[1] = {96'b0, d1};
  assign od[2] = {96'b0, d2};
  assign od[3] = {96'b0, d3};
  assign od[4] = {96'b0, d4};
  assign od[5] = d5;

  fxp_conv_pipe #(.RND(RND_HALF_UP)) u_hu (
    .clk(clk), .reset_(reset_), .in_valid(in_valid),
    .in_ready(ir[0]), .in_data(in_data), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(d0), .out_sat(os[0]),
    .clr_cnt(clr_cnt), .sat_cnt(cnt0));

  fxp_conv_pipe #(.RND(RND_HALF_EVEN)) u_he (
    .clk(clk), .reset_(reset_), .in_valid(in_valid),
    .in_ready(ir[1]), .in_data(in_data), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(d1), .out_sat(os[1]),
    .clr_cnt(clr_cnt), .sat_cnt(cnt1));

  fxp_conv_pipe #(.RND(RND_TRUNC)) u_tr (
    .clk(clk), .reset_(reset_), .in_valid(in_valid),
    .in_ready(ir[2]), .in_data(in_data), .out_valid(ov[2]),
    .out_ready(out_ready), .out_data(d2), .out_sat(os[2]),
    .clr_cnt(clr_cnt), .sat_cnt(cnt2));

  fxp_conv_pipe #(.SAT_EN(1'b0)) u_wr (
    .clk(clk), .reset_(reset_), .in_valid(in_valid),
    .in_ready(ir[3]), .in_data(in_data), .out_valid(ov[3]),
    .out_ready(out_ready), .out_data(d3), .out_sat(os[3]),
    .clr_cnt(clr_cnt), .sat_cnt(cnt3));

  fxp_conv_pipe #(.CNT_W(4)) u_c4 (
    .clk(clk), .reset_(reset_), .in_valid(in_valid),
    .in_ready(ir[4]), .in_data(in_data), .out_valid(ov[4]),
    .out_ready(out_ready), .out_data(d4), .out_sat(os[4]),
    .clr_cnt(clr_cnt), .sat_cnt(cnt4));

  fxp_conv_pipe #(.O_CONF(O32)) u_wd (
    .clk(clk), .reset_(reset_), .in_valid(in_valid),
    .in_ready(ir[5]), .in_data(in_data), .out_valid(ov[5]),
    .out_ready(out_ready), .out_data(d5), .out_sat(os[5]),
    .clr_cnt(clr_cnt), .sat_cnt(cnt5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        ofr   [6] = '{4, 4, 4, 4, 4, 16};
  int        oprec [6] = '{8, 8, 8, 8, 8, 32};
  bit        satv  [6] = '{1, 1, 1, 0, 1, 1};
  rnd_mode_t rndv  [6] = '{RND_HALF_UP, RND_HALF_EVEN, RND_TRUNC,
                           RND_HALF_UP, RND_HALF_UP, RND_HALF_UP};

  typedef struct packed {
    logic [5:0][127:0] d;
    logic [5:0][3:0]   s;
  } exp_t;

  exp_t        q [$];
  logic        m1, m2;
  logic [15:0] mcnt;
  logic [3:0]  mcnt4;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void lane_model(input logic [15:0] x,
                                     input int i,
                                     output logic [31:0] y,
                                     output logic s);
    longint v, p, qq, rem, r, mx, mn;
    int     d;
    logic   inc;
    v = longint'($signed(x));
    d = 8 - ofr[i];
    if (d <= 0) begin
      r = v * (longint'(1) << (-d));
    end else begin
      p  = longint'(1) << d;
      qq = v / p;
      if (qq * p > v) qq = qq - 1;
      rem = v - qq * p;
      inc = 1'b0;
      if (rndv[i] == RND_HALF_UP) inc = (rem * 2 >= p);
      if (rndv[i] == RND_HALF_EVEN)
        inc = (rem * 2 > p) || (rem * 2 == p && qq[0]);
      r = qq + (inc ? 1 : 0);
    end
    mx = (longint'(1) << (oprec[i] - 1)) - 1;
    mn = -(longint'(1) << (oprec[i] - 1));
    s  = (r > mx) || (r < mn);
    if (satv[i] && r > mx) r = mx;
    if (satv[i] && r < mn) r = mn;
    y = 32'(r & ((longint'(1) << oprec[i]) - 1));
  endfunction

  function automatic exp_t model(input logic [63:0] din);
    exp_t        e;
    logic [31:0] y;
    logic        s;
    e = '0;
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 4; k++) begin
        lane_model(din[k*16 +: 16], i, y, s);
        e.d[i] = e.d[i] | (128'(y) << (k * oprec[i]));
        e.s[i][k] = s;
      end
    return e;
  endfunction

  task automatic step(input logic v, input logic [63:0] din,
                      input logic ordy, input logic clr,
                      output logic fired);
    logic a1, a2, anysat, m2n;
    exp_t e;
    in_valid  = v;
    in_data   = din;
    out_ready = ordy;
    clr_cnt   = clr;
    @(negedge clk);
    a2 = !m2 || ordy;
    a1 = !m1 || a2;
    anysat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("in_ready%0d", i), ir[i], a1);
      chk($sformatf("out_valid%0d", i), ov[i], m2);
    end
    chk("sat_cnt", cnt0, mcnt);
    chk("sat_cnt4", cnt4, mcnt4);
    if (m2) begin
      if (q.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = q[0];
        for (int i = 0; i < 6; i++) begin
          chk($sformatf("data%0d", i), od[i], e.d[i]);
          chk($sformatf("sat%0d", i), os[i], e.s[i]);
        end
        if (ordy) begin
          void'(q.pop_front());
          anysat = |e.s[0];
        end
      end
    end
    if (clr) begin
      mcnt  = '0;
      mcnt4 = '0;
    end else if (anysat) begin
      if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      if (mcnt4 != 4'hF) mcnt4 = mcnt4 + 4'd1;
    end
    fired = v && a1;
    if (fired) q.push_back(model(din));
    m2n = a2 ? m1 : m2;
    m1  = a1 ? v : m1;
    m2  = m2n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        f;
    logic [63:0] bt [8];
    logic [63:0] sb;
    int          idx;
    n_tests   = 0;
    n_fail    = 0;
    m1        = 1'b0;
    m2        = 1'b0;
    mcnt      = '0;
    mcnt4     = '0;
    reset_    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov, 6'b0);
    chk("rst_out_data", d0, 32'h0);
    chk("rst_out_sat", os[0], 4'h0);
    chk("rst_sat_cnt", cnt0, 16'h0);
    reset_ = 1'b1;
    #1;
    chk("rst_in_ready", ir, 6'h3F);

    // Rounding corner cases, held at the output while stalled.
    step(1'b1, 64'h0000_0000_FFF8_0128, 1'b0, 1'b0, f);
    step(1'b0, 64'h0, 1'b0, 1'b0, f);
    chk("hu_half_up", d0[7:0], 8'h13);
    chk("he_half_even", d1[7:0], 8'h12);
    chk("tr_floor", d2[15:8], 8'hFF);
    chk("hu_neg_half", d0[15:8], 8'h00);
    chk("hu_no_sat", os[0], 4'h0);
    step(1'b0, 64'h0, 1'b0, 1'b0, f);
    step(1'b0, 64'h0, 1'b1, 1'b0, f);

    // Saturation and wrap.
    step(1'b1, 64'h0100_07F8_F700_0900, 1'b0, 1'b0, f);
    step(1'b0, 64'h0, 1'b0, 1'b0, f);
    chk("hu_clamp", d0, 32'h107F807F);
    chk("hu_clamp_sat", os[0], 4'b0111);
    chk("wr_wrap", d3[7:0], 8'h90);
    chk("wr_wrap_sat", os[3][0], 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b0, f);
    chk("sat_cnt_one", cnt0, 16'd1);

    // Widening sign extension.
    step(1'b1, 64'h0000_0000_0000_8000, 1'b1, 1'b0, f);
    step(1'b0, 64'h0, 1'b1, 1'b0, f);
    chk("wd_sext", d5[31:0], 32'hFF800000);
    step(1'b0, 64'h0, 1'b1, 1'b0, f);

    // Backpressure: out_ready pattern 1,0,0 repeating.
    for (int i = 0; i < 8; i++)
      bt[i] = {$urandom, $urandom};
    idx = 0;
    for (int c = 0; c < 100 && idx < 8; c++) begin
      step(1'b1, bt[idx], (c % 3) == 0, 1'b0, f);
      if (f) idx++;
    end
    chk("bp_sent", idx, 8);
    for (int c = 0; c < 10; c++)
      step(1'b0, 64'h0, 1'b1, 1'b0, f);
    chk("bp_drain", q.size(), 0);

    // clr_cnt against a coincident saturating accept.
    sb = 64'h0900_0900_0900_0900;
    step(1'b1, sb, 1'b1, 1'b0, f);
    step(1'b0, 64'h0, 1'b1, 1'b0, f);
    step(1'b0, 64'h0, 1'b1, 1'b1, f);
    chk("clr_prio", cnt0, 16'd0);

    // 2^4+3 saturating beats hold the 4-bit counter at 0xF.
    for (int j = 0; j < 19; j++)
      step(1'b1, sb, 1'b1, 1'b0, f);
    for (int c = 0; c < 4; c++)
      step(1'b0, 64'h0, 1'b1, 1'b0, f);
    chk("cnt4_hold", cnt4, 4'hF);
    chk("cnt16_count", cnt0, 16'd19);

    // Random traffic.
    for (int c = 0; c < 200; c++)
      step($urandom_range(0, 3) != 0, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0, f);
    for (int c = 0; c < 6; c++)
      step(1'b0, 64'h0, 1'b1, 1'b0, f);
    chk("rand_drain", q.size(), 0);

    // Asynchronous reset with beats in flight.
    for (int c = 0; c < 3; c++)
      step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, f);
    #2;
    reset_ = 1'b0;
    #1;
    chk("arst_out_valid", ov, 6'b0);
    chk("arst_out_data", d0, 32'h0);
    chk("arst_sat_cnt", cnt0, 16'h0);
    q.delete();
    m1    = 1'b0;
    m2    = 1'b0;
    mcnt  = '0;
    mcnt4 = '0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_ = 1'b1;
    for (int c = 0; c < 5; c++)
      step(1'b0, 64'h0, 1'b1, 1'b0, f);
    step(1'b1, 64'h0000_0000_FFF8_0128, 1'b1, 1'b0, f);
    for (int c = 0; c < 4; c++)
      step(1'b0, 64'h0, 1'b1, 1'b0, f);
    chk("post_rst_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
